// File: rtl/ex_mem_datapath.sv
// rtl/ex_mem_datapath.sv - execute/memory slice: ALU control decode, 16-bit ALU, word data memory
module ex_mem_datapath #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       alu_op,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [WIDTH-1:0] mem_addr,
  input  logic [WIDTH-1:0] mem_wdata,
  output logic [3:0]       alu_operation,
  output logic [WIDTH-1:0] alu_result,
  output logic             zero,
  output logic             lt,
  output logic             gt,
  output logic [WIDTH-1:0] mem_rdata
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;
  localparam logic [3:0] OP_NOR   = 4'b1100;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    word_idx;
  logic             unused_addr_hi;

  always_comb begin
    alu_operation = OP_ADD;
    case (alu_op)
      3'b000: alu_operation = OP_ADD;
      3'b001: alu_operation = OP_SUB;
      3'b010: begin
        case (func)
          3'b000: alu_operation = OP_ADD;
          3'b001: alu_operation = OP_SUB;
          3'b010: alu_operation = OP_AND;
          3'b011: alu_operation = OP_OR;
          3'b100: alu_operation = OP_XOR;
          3'b101: alu_operation = OP_NOR;
          3'b110: alu_operation = OP_SLT;
          default: alu_operation = OP_SLL;
        endcase
      end
      3'b011: alu_operation = OP_AND;
      3'b100: alu_operation = OP_OR;
      3'b101: alu_operation = OP_SLT;
      3'b110: alu_operation = OP_PASSB;
      default: alu_operation = OP_ADD;
    endcase
  end

  // Flags compare operands directly so branches see them whatever the op is.
  assign lt = $signed(operand_a) < $signed(operand_b);
  assign gt = $signed(operand_a) > $signed(operand_b);

  always_comb begin
    alu_result = '0;
    case (alu_operation)
      OP_ADD:   alu_result = operand_a + operand_b;
      OP_SUB:   alu_result = operand_a - operand_b;
      OP_AND:   alu_result = operand_a & operand_b;
      OP_OR:    alu_result = operand_a | operand_b;
      OP_XOR:   alu_result = operand_a ^ operand_b;
      OP_NOR:   alu_result = ~(operand_a | operand_b);
      OP_SLT:   alu_result = {{(WIDTH-1){1'b0}}, lt};
      OP_SLL:   alu_result = operand_a << operand_b[3:0];
      OP_SRL:   alu_result = operand_a >> operand_b[3:0];
      OP_PASSB: alu_result = operand_b;
      default:  alu_result = '0;
    endcase
  end

  assign zero = (alu_result == '0);

  // Address wraps modulo DEPTH; upper bits are intentionally ignored.
  assign word_idx       = mem_addr[AW-1:0];
  assign unused_addr_hi = ^mem_addr[WIDTH-1:AW];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (mem_write) begin
      mem[word_idx] <= mem_wdata;
    end
  end

  assign mem_rdata = mem_read ? mem[word_idx] : '0;

endmodule

// File: tb/tb_ex_mem_datapath.sv
// tb/tb_ex_mem_datapath.sv - directed self-checking bench for ex_mem_datapath
module tb_ex_mem_datapath;

  logic        clk;
  logic        rst;
  logic [2:0]  alu_op;
  logic [2:0]  func;
  logic [15:0] operand_a;
  logic [15:0] operand_b;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [3:0]  alu_operation;
  logic [15:0] alu_result;
  logic        zero;
  logic        lt;
  logic        gt;
  logic [15:0] mem_rdata;

  int checks;
  int errors;

  logic [3:0] exp_rtype [8] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                4'b0011, 4'b1100, 4'b0111, 4'b1000};

  ex_mem_datapath #(.DEPTH(256), .WIDTH(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_op        (alu_op),
    .func          (func),
    .operand_a     (operand_a),
    .operand_b     (operand_b),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .alu_operation (alu_operation),
    .alu_result    (alu_result),
    .zero          (zero),
    .lt            (lt),
    .gt            (gt),
    .mem_rdata     (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic alu_vec(input logic [2:0] op, input logic [2:0] fn,
                         input logic [15:0] a, input logic [15:0] b);
    alu_op = op;
    func = fn;
    operand_a = a;
    operand_b = b;
    #1;
  endtask

  task automatic write_word(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk);
    mem_write = 1'b1;
    mem_read = 1'b0;
    mem_addr = addr;
    mem_wdata = data;
    @(posedge clk);
    #1;
    mem_write = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] addr,
                            input logic rd, input logic [15:0] exp);
    @(negedge clk);
    mem_read = rd;
    mem_addr = addr;
    #1;
    check(tag, mem_rdata, exp);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    alu_op = 3'b000;
    func = 3'b000;
    operand_a = '0;
    operand_b = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_addr = '0;
    mem_wdata = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    read_check("reset_rd3", 16'd3, 1'b1, 16'h0000);
    read_check("reset_rd200", 16'd200, 1'b1, 16'h0000);

    for (int i = 0; i < 8; i++) begin
      alu_vec(3'b010, 3'(i), 16'h0, 16'h0);
      check($sformatf("rtype_func%0d", i), {12'h0, alu_operation}, {12'h0, exp_rtype[i]});
    end
    alu_vec(3'b001, 3'b000, 16'h0, 16'h0);
    check("ctl_branch", {12'h0, alu_operation}, 16'h0006);
    alu_vec(3'b110, 3'b000, 16'h0, 16'h1234);
    check("ctl_passb", {12'h0, alu_operation}, 16'h000A);
    check("passb_res", alu_result, 16'h1234);

    alu_vec(3'b000, 3'b000, 16'h7FFF, 16'h0001);
    check("add_res", alu_result, 16'h8000);
    check("add_zlg", {13'h0, zero, lt, gt}, 16'h0001);

    alu_vec(3'b001, 3'b000, 16'h0005, 16'h0005);
    check("sub_eq_res", alu_result, 16'h0000);
    check("sub_eq_zlg", {13'h0, zero, lt, gt}, 16'h0004);

    alu_vec(3'b001, 3'b000, 16'hFFFF, 16'h0001);
    check("sub_neg_res", alu_result, 16'hFFFE);
    check("sub_neg_zlg", {13'h0, zero, lt, gt}, 16'h0002);

    alu_vec(3'b010, 3'b010, 16'hF0F0, 16'h0FF0);
    check("and_res", alu_result, 16'h00F0);
    alu_vec(3'b010, 3'b011, 16'hF0F0, 16'h0FF0);
    check("or_res", alu_result, 16'hFFF0);
    alu_vec(3'b010, 3'b100, 16'hF0F0, 16'h0FF0);
    check("xor_res", alu_result, 16'hFF00);
    alu_vec(3'b010, 3'b101, 16'hF0F0, 16'h0FF0);
    check("nor_res", alu_result, 16'h000F);
    alu_vec(3'b010, 3'b111, 16'h0001, 16'h0013);
    check("sll_res", alu_result, 16'h0008);
    alu_vec(3'b010, 3'b110, 16'h8000, 16'h0000);
    check("slt_res", alu_result, 16'h0001);
    alu_vec(3'b101, 3'b000, 16'h0003, 16'h0002);
    check("slti_false", alu_result, 16'h0000);

    write_word(16'd3, 16'hBEEF);
    read_check("rd3", 16'd3, 1'b1, 16'hBEEF);
    read_check("rd3_noread", 16'd3, 1'b0, 16'h0000);
    read_check("rd259_wrap", 16'd259, 1'b1, 16'hBEEF);
    read_check("rd4_untouched", 16'd4, 1'b1, 16'h0000);

    write_word(16'd7, 16'h1111);
    @(negedge clk);
    mem_addr = 16'd7;
    mem_wdata = 16'h2222;
    mem_read = 1'b1;
    mem_write = 1'b1;
    #1;
    check("rw_before", mem_rdata, 16'h1111);
    @(posedge clk);
    #1;
    mem_write = 1'b0;
    check("rw_after", mem_rdata, 16'h2222);

    for (int i = 0; i < 4; i++) begin
      write_word(16'(i), 16'h5A00 + 16'(i));
    end
    read_check("pre_rst_rd2", 16'd2, 1'b1, 16'h5A02);
    @(negedge clk);
    rst = 1'b1;
    mem_write = 1'b1;
    mem_addr = 16'd4;
    mem_wdata = 16'hAAAA;
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_write = 1'b0;
    for (int i = 0; i < 5; i++) begin
      read_check($sformatf("post_rst_rd%0d", i), 16'(i), 1'b1, 16'h0000);
    end
    read_check("post_rst_rd7", 16'd7, 1'b1, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
